// File: rtl/pmod_als_emulator.sv
// ---------------------------------------------------------------------------
// pmod_als_emulator
//   SPI responder that looks like a PmodALS light sensor (ADC081S021 frame
//   format). A local sample is shifted out on sdo, MSB first, in response to
//   cs/sck from an external or on-chip master. The frame on sdo is
//   LEAD_ZEROS zeros, DATA_WIDTH data bits, then zeros until cs rises.
//
// Ports
//   clk         system clock (the only clock)
//   rst_n       asynchronous active-low reset
//   value_in    sample to transmit, captured at the start of each frame
//   cs          chip select from the master, active low, async to clk
//   sck         serial clock from the master, async to clk, idles low
//   sdo         serial data to the master
//   sdo_oe      high while a frame is active
//   frame_done  1-clk pulse: frame closed with enough rising sck edges
//   frame_err   1-clk pulse: frame closed early
//   frame_cnt   count of good frames, wraps FFFF -> 0000
//
// Handshake: there is no valid/ready pair here. The master owns timing; a
// frame starts on synced cs falling, the master samples sdo on sck rising,
// sdo advances on sck falling, and the frame closes on synced cs rising.
// ---------------------------------------------------------------------------
module pmod_als_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_ZEROS  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] value_in,
  input  logic                  cs,
  input  logic                  sck,
  output logic                  sdo,
  output logic                  sdo_oe,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
  localparam logic [CW-1:0] GOOD_EDGES = CW'(LEAD_ZEROS + DATA_WIDTH);
  localparam logic [CW-1:0] MAX_EDGES  = CW'(FRAME_BITS);

  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_SHIFT} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
  logic                   cs_d, sck_d;
  logic                   cs_s, sck_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;
  logic [SYNC_STAGES:0]   warm;
  logic                   sync_ok;
  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  load_word;
  logic [CW-1:0]          edge_cnt;

  // Synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      cs_d     <= 1'b1;
      sck_d    <= 1'b0;
      warm     <= '0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_d     <= cs_s;
      sck_d    <= sck_s;
      warm     <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;

  // The sync chain comes out of reset preset to "cs high", which says
  // nothing about the real pin. Only trust cs once the physical level has
  // propagated through every stage and the history flop.
  assign sync_ok = warm[SYNC_STAGES];

  assign load_word = {{LEAD_ZEROS{1'b0}}, value_in, {TAIL_ZEROS{1'b0}}};

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      S_WAIT:  if (sync_ok && cs_s && cs_d) next_state = S_IDLE;
      S_IDLE:  if (cs_fall) next_state = S_SHIFT;
      S_SHIFT: if (cs_rise) next_state = S_IDLE;
      default: next_state = S_WAIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sdo_oe = 1'b0;
    if (state == S_SHIFT) sdo_oe = 1'b1;
  end

  // Datapath: shift register, edge counter, status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo        <= 1'b0;
      shreg      <= '0;
      edge_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          sdo <= 1'b0;
          if (cs_fall) begin
            shreg    <= load_word;
            sdo      <= load_word[FRAME_BITS-1];
            edge_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (cs_rise) begin
            // cs_rise wins over any sck edge seen in the same clock.
            sdo <= 1'b0;
            if (edge_cnt >= GOOD_EDGES) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sck_rise && edge_cnt != MAX_EDGES) edge_cnt <= edge_cnt + 1'b1;
            // A falling edge before the first rising edge (cs fell while
            // sck was high) must not consume bit 0.
            if (sck_fall && edge_cnt != '0) begin
              shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
              sdo   <= shreg[FRAME_BITS-2];
            end
          end
        end
        default: sdo <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_als_emulator.sv
module tb_pmod_als_emulator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  value_in;
  logic        cs;
  logic        sck;
  logic        sdo;
  logic        sdo_oe;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int tests  = 0;
  int failed = 0;
  int done_seen = 0;
  int err_seen  = 0;

  pmod_als_emulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .cs         (cs),
    .sck        (sck),
    .sdo        (sdo),
    .sdo_oe     (sdo_oe),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: a pulse wider than one clock is counted more than once.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) done_seen++;
      if (frame_err)  err_seen++;
    end
  end

  typedef struct {
    logic [7:0] value;
    int         n_edges;
    int         chg_at;
    logic [7:0] chg_val;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Master driver: 8-clk sck half-period. Samples sdo just before each
  // rising edge, optionally changes value_in after rising edge chg_at.
  task automatic run_frame(input int n, input int chg_at, input logic [7:0] chg_val,
                           output logic [31:0] cap, output logic oe_ok);
    cap   = '0;
    oe_ok = 1'b1;
    cs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < n; i++) begin
      if (sdo_oe !== 1'b1) oe_ok = 1'b0;
      cap = {cap[30:0], sdo};
      sck = 1'b1;
      wait_clk(8);
      if (i + 1 == chg_at) value_in = chg_val;
      sck = 1'b0;
      wait_clk(8);
    end
    cs = 1'b1;
    wait_clk(10);
  endtask

  // Expected sdo bits for the first n rising edges, first bit in the MSB
  // of the n-bit result: 3 zeros, the sample, then zeros.
  function automatic logic [31:0] model_bits(input logic [7:0] v, input int n);
    logic [31:0] frame32;
    frame32 = {3'b000, v, 21'b0};
    return frame32 >> (32 - n);
  endfunction

  initial begin
    logic [31:0] cap;
    logic        oe_ok;
    logic [15:0] exp_cnt;
    int          d0, e0;

    // Reset
    rst_n    = 1'b0;
    cs       = 1'b1;
    sck      = 1'b0;
    value_in = 8'h00;
    exp_cnt  = 16'h0000;
    wait_clk(3);
    check("reset_sdo",        {31'b0, sdo},        32'd0);
    check("reset_sdo_oe",     {31'b0, sdo_oe},     32'd0);
    check("reset_frame_done", {31'b0, frame_done}, 32'd0);
    check("reset_frame_err",  {31'b0, frame_err},  32'd0);
    check("reset_frame_cnt",  {16'b0, frame_cnt},  32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    // Table of full/partial frames
    vecs.push_back('{8'hA5, 16, 0, 8'h00, 1, 0});  // basic frame
    vecs.push_back('{8'h3C, 16, 5, 8'hFF, 1, 0});  // value_in changes mid-frame
    vecs.push_back('{8'h5A,  6, 0, 8'h00, 0, 1});  // early cs rise
    vecs.push_back('{8'h5A, 16, 0, 8'h00, 1, 0});  // recovery after error
    vecs.push_back('{8'hFF, 20, 0, 8'h00, 1, 0});  // overlong frame
    vecs.push_back('{8'h81, 11, 0, 8'h00, 1, 0});  // exactly enough edges
    vecs.push_back('{8'h81, 10, 0, 8'h00, 0, 1});  // one edge short

    foreach (vecs[k]) begin
      value_in = vecs[k].value;
      d0 = done_seen;
      e0 = err_seen;
      run_frame(vecs[k].n_edges, vecs[k].chg_at, vecs[k].chg_val, cap, oe_ok);
      if (vecs[k].exp_done != 0) exp_cnt = exp_cnt + 16'd1;
      check($sformatf("v%0d_bits", k), cap, model_bits(vecs[k].value, vecs[k].n_edges));
      check($sformatf("v%0d_sdo_oe", k), {31'b0, oe_ok}, 32'd1);
      check($sformatf("v%0d_done", k), done_seen - d0, vecs[k].exp_done);
      check($sformatf("v%0d_err", k), err_seen - e0, vecs[k].exp_err);
      check($sformatf("v%0d_cnt", k), {16'b0, frame_cnt}, {16'b0, exp_cnt});
      check($sformatf("v%0d_idle_oe", k), {31'b0, sdo_oe}, 32'd0);
    end

    // Reset asserted mid-frame after rising edge 5
    value_in = 8'hC3;
    d0 = done_seen;
    e0 = err_seen;
    cs = 1'b0;
    wait_clk(8);
    cap = '0;
    for (int i = 0; i < 5; i++) begin
      cap = {cap[30:0], sdo};
      sck = 1'b1; wait_clk(8);
      sck = 1'b0; wait_clk(8);
    end
    check("mid_pre_bits", cap, model_bits(8'hC3, 5));
    sck = 1'b1;
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sdo",    {31'b0, sdo},    32'd0);
    check("mid_rst_sdo_oe", {31'b0, sdo_oe}, 32'd0);
    check("mid_rst_cnt",    {16'b0, frame_cnt}, 32'd0);
    exp_cnt = 16'h0000;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    sck = 1'b0;
    wait_clk(8);
    oe_ok = 1'b1;
    cap = '0;
    for (int i = 0; i < 10; i++) begin
      if (sdo_oe !== 1'b0) oe_ok = 1'b0;
      cap = {cap[30:0], sdo};
      sck = 1'b1; wait_clk(8);
      sck = 1'b0; wait_clk(8);
    end
    cs = 1'b1;
    wait_clk(10);
    check("mid_rest_quiet_oe", {31'b0, oe_ok}, 32'd1);
    check("mid_rest_sdo",      cap, 32'd0);
    check("mid_rest_done",     done_seen - d0, 32'd0);
    check("mid_rest_err",      err_seen - e0, 32'd0);
    value_in = 8'h96;
    run_frame(16, 0, 8'h00, cap, oe_ok);
    exp_cnt = exp_cnt + 16'd1;
    check("post_rst_bits", cap, model_bits(8'h96, 16));
    check("post_rst_cnt",  {16'b0, frame_cnt}, {16'b0, exp_cnt});

    // frame_cnt wrap
    force dut.frame_cnt = 16'hFFFF;
    wait_clk(1);
    release dut.frame_cnt;
    wait_clk(1);
    check("wrap_preload", {16'b0, frame_cnt}, 32'h0000_FFFF);
    d0 = done_seen;
    value_in = 8'h42;
    run_frame(16, 0, 8'h00, cap, oe_ok);
    check("wrap_bits", cap, model_bits(8'h42, 16));
    check("wrap_cnt",  {16'b0, frame_cnt}, 32'h0000_0000);
    check("wrap_done", done_seen - d0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
